// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - single-outstanding instruction fetch FSM with redirect and halt
// Fetches one word at a time, issues it, and follows redirects or halts from the datapath.
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC        = 32'h00000000,
  parameter int          IMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imemReq,
  output logic [IMEM_ADDR_WIDTH-1:0] imemAddr,
  input  logic                       imemAck,
  input  logic [31:0]                imemData,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirectTarget,
  input  logic                       halt,
  output logic                       instrValid,
  output logic [31:0]                instruction,
  output logic [5:0]                 operator,
  output logic [5:0]                 special,
  output logic [31:0]                pc,
  output logic                       halted
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [31:0] target_aligned;
  logic        unused_target_bits;

  assign target_aligned     = {redirectTarget[31:2], 2'b00};
  assign unused_target_bits = ^redirectTarget[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instruction <= 32'h0;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (halt) begin
            state <= HALTED;
          end else if (imemAck) begin
            pend_valid <= 1'b0;
            // A redirect seen during this fetch makes the returned word stale.
            if (redirect) begin
              pc <= target_aligned;
            end else if (pend_valid) begin
              pc <= pend_target;
            end else begin
              instruction <= imemData;
              state       <= ISSUE;
            end
          end else if (redirect) begin
            // Address must stay put until the outstanding fetch returns.
            pend_valid  <= 1'b1;
            pend_target <= target_aligned;
          end
        end
        ISSUE: begin
          if (halt) begin
            state <= HALTED;
          end else if (redirect) begin
            pc    <= target_aligned;
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc + 32'd4;
            state <= FETCH;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

  assign imemReq    = rst_n && (state == FETCH);
  assign imemAddr   = pc[IMEM_ADDR_WIDTH+1:2];
  assign instrValid = (state == ISSUE);
  assign halted     = (state == HALTED);
  assign operator   = instruction[31:26];
  assign special    = instruction[5:0];

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - randomized scoreboard bench for instruction_fetcher
module tb_instruction_fetcher;

  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam int          AW       = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imemReq;
  logic [AW-1:0] imemAddr;
  logic          imemAck = 1'b0;
  logic [31:0]   imemData = 32'h0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirectTarget = 32'h0;
  logic          halt = 1'b0;
  logic          instrValid;
  logic [31:0]   instruction;
  logic [5:0]    operator;
  logic [5:0]    special;
  logic [31:0]   pc;
  logic          halted;

  instruction_fetcher #(.RESET_PC(RESET_PC), .IMEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData), .stall(stall), .redirect(redirect),
    .redirectTarget(redirectTarget), .halt(halt), .instrValid(instrValid),
    .instruction(instruction), .operator(operator), .special(special),
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  int checks = 0;
  int failures = 0;

  // Scoreboard: head is the byte address the next issued instruction must carry.
  logic [31:0] exp_q[$];
  bit   mon_en = 1'b0;
  bit   pend = 1'b0;
  bit   exp_valid_next = 1'b0;
  bit   prev_req = 1'b0;
  bit   prev_ack = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  bit   wrapped = 1'b0;
  bit   saw_zero = 1'b0;
  int   issues = 0;
  int   wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    logic [AW-1:0] idx;
    idx = byte_addr[AW+1:2];
    return mem[idx];
  endfunction

  // Memory responder: acks requests after a random number of wait cycles.
  always begin
    @(negedge clk);
    #1;
    if (imemReq && wait_cnt == 0) begin
      imemAck  = 1'b1;
      imemData = mem[imemAddr];
      wait_cnt = $urandom_range(0, 4);
    end else begin
      imemAck  = 1'b0;
      imemData = $urandom;
      if (imemReq && wait_cnt > 0) wait_cnt--;
    end
  end

  // Monitor: compares presented instructions with the scoreboard and applies the model rules.
  always begin
    logic [31:0] p, w, t;
    logic [AW-1:0] ea;
    @(negedge clk);
    #2;
    if (mon_en && rst_n && !halt) begin
      t = {redirectTarget[31:2], 2'b00};
      if (exp_valid_next) chk("ack_to_valid_latency", 32'(instrValid), 32'd1);
      exp_valid_next = 1'b0;
      if (prev_req && !prev_ack && imemReq) chk("addr_stable", 32'(imemAddr), 32'(prev_addr));
      if (instrValid) begin
        p = exp_q[0];
        w = word_at(p);
        chk("issue_pc", pc, p);
        chk("issue_instruction", instruction, w);
        chk("issue_operator", 32'(operator), 32'(w[31:26]));
        chk("issue_special", 32'(special), 32'(w[5:0]));
        chk("no_req_in_issue", 32'(imemReq), 32'd0);
        if (redirect || !stall) begin
          void'(exp_q.pop_front());
          issues++;
          if (wrapped && p == 32'h0) saw_zero = 1'b1;
          if (p == 32'hFFFFFFFC && !redirect) wrapped = 1'b1;
          exp_q.push_back(redirect ? t : p + 32'd4);
        end
      end else if (imemReq) begin
        p = exp_q[0];
        ea = p[AW+1:2];
        if (!pend) chk("fetch_addr", 32'(imemAddr), 32'(ea));
        if (imemAck) begin
          if (!redirect && !pend) exp_valid_next = 1'b1;
          pend = 1'b0;
          if (redirect) exp_q[0] = t;
        end else if (redirect) begin
          pend = 1'b1;
          exp_q[0] = t;
        end
      end
      prev_req  = imemReq;
      prev_ack  = imemAck;
      prev_addr = imemAddr;
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic wait_issue();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (instrValid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_issue actual=timeout required=instrValid");
    end
  endtask

  task automatic run_random(input int cycles, input int redir_pct);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      stall          = ($urandom_range(0, 99) < 30);
      redirect       = ($urandom_range(0, 99) < redir_pct);
      redirectTarget = $urandom;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_imemReq"}, 32'(imemReq), 32'd0);
    chk({tag, "_instrValid"}, 32'(instrValid), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_instruction"}, instruction, 32'h0);
  endtask

  initial begin
    logic [31:0] hpc;
    logic [AW-1:0] rst_word;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[0] = 32'h00000020;
    mem[2] = 32'h8C000000;
    rst_word = RESET_PC[AW+1:2];
    exp_q.push_back(RESET_PC);

    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1;
    chk("first_req", 32'(imemReq), 32'd1);
    chk("first_addr", 32'(imemAddr), 32'(rst_word));

    run_random(1500, 8);

    // Stall an issued instruction, then pulse reset between clock edges.
    redirect = 1'b0;
    stall    = 1'b1;
    wait_issue();
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    #1;
    check_reset_values("held_reset");
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    pend           = 1'b0;
    exp_valid_next = 1'b0;
    rst_n          = 1'b1;
    stall          = 1'b0;
    mon_en         = 1'b1;

    // Unaligned target to the last word of the address space, then sequential wrap.
    redirect       = 1'b1;
    redirectTarget = 32'hFFFFFFFF;
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 99) < 30);
    end
    chk("wrap_to_zero_issued", 32'(saw_zero), 32'd1);

    run_random(800, 10);

    // Halt and redirect in the same issue cycle: halt wins.
    redirect = 1'b0;
    stall    = 1'b1;
    wait_issue();
    hpc            = exp_q[0];
    halt           = 1'b1;
    redirect       = 1'b1;
    redirectTarget = $urandom;
    @(negedge clk);
    mon_en = 1'b0;
    halt   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_instrValid", 32'(instrValid), 32'd0);
      chk("halt_imemReq", 32'(imemReq), 32'd0);
      chk("halt_pc", pc, hpc);
      @(negedge clk);
      redirect       = $urandom_range(0, 1);
      stall          = $urandom_range(0, 1);
      redirectTarget = $urandom;
    end

    checks++;
    if (issues < 200) begin
      failures++;
      $display("FAIL issue_count actual=%0d required=>=200", issues);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
